calc_key_sequencer: RTL and testbench

- Front-end controller for the two-function calculator datapath.
- Debounces the board's active-low pushbuttons and samples the 8-bit switch bank.
- Sequences operand entry (A, then B), then the result capture (Z).
- Drives the datapath's active-low load strobes, shared data bus, function select (C0) and clear, i.e. it is the initiator for the load/clear interface the datapath responds to.

---
 rtl/calc_key_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: key debounce and operand/result load sequencing
// for the two-function calculator datapath (A, B, Z registers, add/sub).
`timescale 1ns/1ps
module calc_key_sequencer #(
  parameter int DEB_CYCLES = 50000,
  parameter int PULSE_LEN  = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] sw,
  input  logic       key_enter_n,
  input  logic       key_op_n,
  input  logic       key_clear_n,
  output logic [7:0] data_out,
  output logic       loadA,
  output logic       loadB,
  output logic       loadZ,
  output logic       C0,
  output logic       clr_out,
  output logic [1:0] state,
  output logic       busy
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    COMPUTE = 2'd2,
    RESULT  = 2'd3
  } st_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_CAP,
    PH_PULSE,
    PH_SETTLE,
    PH_CLEAR
  } ph_e;

  // key index: 0 = enter, 1 = op, 2 = clear
  logic [2:0] key_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] deb_q;
  logic [2:0] deb_d;
  logic [2:0] ev_q;
  logic [2:0] ev_d;
  logic [2:0][DW-1:0] cnt_q;
  logic [2:0][DW-1:0] cnt_d;

  assign key_raw = {key_clear_n, key_op_n, key_enter_n};

  // Debounce: flip the accepted level after DEB_CYCLES differing
  // samples in a row; a flip towards 0 is a press event.
  always_comb begin
    deb_d = deb_q;
    ev_d  = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
          ev_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchronizer, debounce and event registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      ev_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      ev_q    <= ev_d;
      cnt_q   <= cnt_d;
    end
  end

  logic ev_enter;
  logic ev_op;
  logic ev_clr;

  assign ev_enter = ev_q[0];
  assign ev_op    = ev_q[1];
  assign ev_clr   = ev_q[2];

  st_e          st_q;
  st_e          st_d;
  ph_e          ph_q;
  ph_e          ph_d;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;
  logic [7:0]   data_q;
  logic [7:0]   data_d;
  logic         la_q;
  logic         la_d;
  logic         lb_q;
  logic         lb_d;
  logic         lz_q;
  logic         lz_d;
  logic         c0_q;
  logic         c0_d;
  logic         clr_q;
  logic         clr_d;
  logic         busy_q;
  logic         busy_d;
  logic         pc_done;

  assign pc_done = (pc_q == PW'(PULSE_LEN));

  // Sequencer next state: clear preempts everything, otherwise a
  // running phase advances and new enter/op events are ignored.
  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    pc_d   = pc_q;
    data_d = data_q;
    la_d   = la_q;
    lb_d   = lb_q;
    lz_d   = lz_q;
    c0_d   = c0_q;
    clr_d  = clr_q;
    busy_d = busy_q;
    if (ev_clr) begin
      la_d   = 1'b1;
      lb_d   = 1'b1;
      lz_d   = 1'b1;
      clr_d  = 1'b1;
      c0_d   = 1'b0;
      data_d = 8'h00;
      busy_d = 1'b1;
      ph_d   = PH_CLEAR;
      pc_d   = PW'(1);
    end else begin
      unique case (ph_q)
        PH_IDLE: begin
          if (ev_enter) begin
            unique case (st_q)
              ENTER_A, ENTER_B: begin
                data_d = sw;
                busy_d = 1'b1;
                ph_d   = PH_CAP;
              end
              RESULT:  st_d = ENTER_A;
              default: ;
            endcase
          end else if (ev_op) begin
            c0_d = ~c0_q;
            if (st_q == RESULT) begin
              st_d   = COMPUTE;
              busy_d = 1'b1;
              ph_d   = PH_SETTLE;
              pc_d   = PW'(1);
            end
          end
        end
        PH_CAP: begin
          ph_d = PH_PULSE;
          pc_d = PW'(1);
          if (st_q == ENTER_A) la_d = 1'b0;
          else                 lb_d = 1'b0;
        end
        PH_PULSE: begin
          if (pc_done) begin
            la_d = 1'b1;
            lb_d = 1'b1;
            lz_d = 1'b1;
            unique case (st_q)
              ENTER_A: begin
                st_d   = ENTER_B;
                busy_d = 1'b0;
                ph_d   = PH_IDLE;
              end
              ENTER_B: begin
                st_d = COMPUTE;
                ph_d = PH_SETTLE;
                pc_d = PW'(1);
              end
              default: begin
                st_d   = RESULT;
                busy_d = 1'b0;
                ph_d   = PH_IDLE;
              end
            endcase
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        PH_SETTLE: begin
          if (pc_done) begin
            lz_d = 1'b0;
            ph_d = PH_PULSE;
            pc_d = PW'(1);
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        PH_CLEAR: begin
          if (pc_done) begin
            clr_d  = 1'b0;
            busy_d = 1'b0;
            st_d   = ENTER_A;
            ph_d   = PH_IDLE;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        default: ph_d = PH_IDLE;
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      st_q   <= ENTER_A;
      ph_q   <= PH_IDLE;
      pc_q   <= '0;
      data_q <= 8'h00;
      la_q   <= 1'b1;
      lb_q   <= 1'b1;
      lz_q   <= 1'b1;
      c0_q   <= 1'b0;
      clr_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      pc_q   <= pc_d;
      data_q <= data_d;
      la_q   <= la_d;
      lb_q   <= lb_d;
      lz_q   <= lz_d;
      c0_q   <= c0_d;
      clr_q  <= clr_d;
      busy_q <= busy_d;
    end
  end

  assign data_out = data_q;
  assign loadA    = la_q;
  assign loadB    = lb_q;
  assign loadZ    = lz_q;
  assign C0       = c0_q;
  assign clr_out  = clr_q;
  assign state    = st_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: directed scenarios against a cycle-level
// output timeline model plus a small calculator datapath model.
`timescale 1ns/1ps
module tb_calc_key_sequencer;

  localparam int DEB = 4;
  localparam int PL  = 2;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] sw  = 8'h00;
  logic       ken = 1'b1;
  logic       kop = 1'b1;
  logic       kclr = 1'b1;
  logic [7:0] data_out;
  logic       loadA, loadB, loadZ, C0, clr_out, busy;
  logic [1:0] state;

  calc_key_sequencer #(.DEB_CYCLES(DEB), .PULSE_LEN(PL)) dut (
    .CLK(CLK), .CLR(CLR), .sw(sw),
    .key_enter_n(ken), .key_op_n(kop), .key_clear_n(kclr),
    .data_out(data_out), .loadA(loadA), .loadB(loadB),
    .loadZ(loadZ), .C0(C0), .clr_out(clr_out),
    .state(state), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected-output timeline model: each accepted event schedules the
  // output snapshots of the cycles that follow it.
  typedef struct packed {
    logic       la;
    logic       lb;
    logic       lz;
    logic       clr;
    logic       busy;
    logic [1:0] st;
    logic       c0;
    logic [7:0] d;
  } snap_t;

  snap_t cur;
  snap_t q[$];
  logic [DEB+1:0] hist [3];
  logic [2:0] mdeb;
  logic [2:0] pend;

  task automatic push_compute(input snap_t b);
    snap_t t;
    t = b;
    t.st = 2'd2;
    t.busy = 1'b1;
    for (int i = 0; i < PL; i++) q.push_back(t);
    t.lz = 1'b0;
    for (int i = 0; i < PL; i++) q.push_back(t);
    t.lz = 1'b1;
    t.st = 2'd3;
    t.busy = 1'b0;
    q.push_back(t);
  endtask

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cur = '{la:1'b1, lb:1'b1, lz:1'b1, clr:1'b0, busy:1'b0,
              st:2'd0, c0:1'b0, d:8'h00};
      q.delete();
      mdeb = '1;
      pend = '0;
      for (int k = 0; k < 3; k++) hist[k] = '1;
    end else begin
      snap_t s;
      snap_t s2;
      logic [2:0] ev;
      logic [2:0] raw;
      ev = pend;
      s = cur;
      if (ev[2]) begin
        q.delete();
        s.la = 1'b1; s.lb = 1'b1; s.lz = 1'b1;
        s.clr = 1'b1; s.busy = 1'b1; s.c0 = 1'b0; s.d = 8'h00;
        for (int i = 0; i < PL; i++) q.push_back(s);
        s.clr = 1'b0; s.busy = 1'b0; s.st = 2'd0;
        q.push_back(s);
      end else if (q.size() == 0 && ev[0]) begin
        if (cur.st == 2'd3) begin
          s.st = 2'd0;
          q.push_back(s);
        end else if (cur.st < 2'd2) begin
          s.d = sw;
          s.busy = 1'b1;
          q.push_back(s);
          s2 = s;
          if (cur.st == 2'd0) s2.la = 1'b0;
          else                s2.lb = 1'b0;
          for (int i = 0; i < PL; i++) q.push_back(s2);
          if (cur.st == 2'd0) begin
            s.st = 2'd1;
            s.busy = 1'b0;
            q.push_back(s);
          end else begin
            push_compute(s);
          end
        end
      end else if (q.size() == 0 && ev[1]) begin
        s.c0 = ~s.c0;
        if (cur.st == 2'd3) push_compute(s);
        else                q.push_back(s);
      end
      if (q.size() != 0) cur = q.pop_front();
      raw = {kclr, kop, ken};
      pend = '0;
      for (int k = 0; k < 3; k++) begin
        logic diff;
        hist[k] = {hist[k][DEB:0], raw[k]};
        diff = 1'b1;
        for (int i = 2; i < DEB + 2; i++)
          if (hist[k][i] == mdeb[k]) diff = 1'b0;
        if (diff) begin
          mdeb[k] = ~mdeb[k];
          if (!mdeb[k]) pend[k] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (!CLR) begin
      logic [15:0] act;
      act = {loadA, loadB, loadZ, clr_out, busy, state, C0, data_out};
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL cycle t=%0t: got 0x%04h expected 0x%04h",
                 $time, act, cur);
      end
      checks++;
      if ((int'(!loadA) + int'(!loadB) + int'(!loadZ) > 1) ||
          (clr_out && !(loadA && loadB && loadZ))) begin
        errors++;
        $display("FAIL excl t=%0t: got A%b B%b Z%b clr%b expected one low max",
                 $time, loadA, loadB, loadZ, clr_out);
      end
    end
  end

  // Datapath model: registers load on the falling edge of their strobe.
  logic [7:0] dA = 8'h00, dB = 8'h00, dZ = 8'h00;
  logic       dCout = 1'b0;
  int pA = 0, pB = 0, pZ = 0;
  int lowA = 0, lowB = 0, lowZ = 0, clrc = 0;
  logic [1:0] trace[$];
  logic [1:0] last_st = 2'd0;

  always @(negedge loadA) begin dA = data_out; pA++; end
  always @(negedge loadB) begin dB = data_out; pB++; end
  always @(negedge loadZ) begin
    logic [8:0] r;
    if (C0) r = {1'b0, dA} + {1'b0, ~dB} + 9'd1;
    else    r = {1'b0, dA} + {1'b0, dB};
    {dCout, dZ} = r;
    pZ++;
  end
  always @(posedge clr_out) begin
    dA = 8'h00; dB = 8'h00; dZ = 8'h00; dCout = 1'b0;
  end
  always @(negedge CLK) begin
    if (!loadA) lowA++;
    if (!loadB) lowB++;
    if (!loadZ) lowZ++;
    if (clr_out) clrc++;
    if (state != last_st) begin
      trace.push_back(state);
      last_st = state;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input int k);
    if (k == 0) ken = 1'b0;
    else if (k == 1) kop = 1'b0;
    else kclr = 1'b0;
    cyc(10);
    ken = 1'b1; kop = 1'b1; kclr = 1'b1;
    cyc(20);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: got busy after %0d cycles expected idle", name, n);
    end
  endtask

  task automatic wait_low(input string name, input int which,
                          input int lim, output int n);
    n = 0;
    while (((which == 0) ? loadA : loadB) && n < lim) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if ((which == 0) ? loadA : loadB) begin
      errors++;
      $display("FAIL %s: got no strobe within %0d cycles expected low",
               name, lim);
    end
  endtask

  initial begin
    int n;
    int pa0, pb0;
    CLR = 1'b1;
    cyc(3);
    chk("rst_loads", {loadA, loadB, loadZ}, 3'b111);
    chk("rst_misc", {clr_out, busy, C0, state}, 5'b0);
    chk("rst_data", data_out, 8'h00);
    CLR = 1'b0;
    pA = 0; pB = 0; pZ = 0; lowA = 0; lowB = 0; lowZ = 0; clrc = 0;
    cyc(2);

    // Full add sequence
    sw = 8'h3C;
    press(0);
    chk("add_A", dA, 8'h3C);
    chk("add_st1", state, 2'd1);
    chk("add_lowA", lowA, 2);
    sw = 8'h05;
    press(0);
    wait_idle("add_idle");
    chk("add_B", dB, 8'h05);
    chk("add_Z", dZ, 8'h41);
    chk("add_st3", state, 2'd3);
    chk("add_pulses", {pA[7:0], pB[7:0], pZ[7:0]}, 24'h010101);
    chk("add_lowBZ", {lowB[7:0], lowZ[7:0]}, 16'h0202);

    // Recompute with subtract
    press(1);
    wait_idle("sub_idle");
    chk("sub_C0", C0, 1'b1);
    chk("sub_Z", dZ, 8'h37);
    chk("sub_st", state, 2'd3);
    chk("sub_pulses", {pA[7:0], pB[7:0], pZ[7:0]}, 24'h010102);

    // Wrap-around: RESULT -> ENTER_A -> new pair 0xFF + 0x01
    trace.delete();
    last_st = state;
    press(0);
    chk("wrap_st0", state, 2'd0);
    press(1);
    chk("wrap_C0", C0, 1'b0);
    sw = 8'hFF;
    press(0);
    sw = 8'h01;
    press(0);
    wait_idle("wrap_idle");
    chk("wrap_ntr", trace.size(), 4);
    chk("wrap_tr", {trace[0], trace[1], trace[2], trace[3]}, 8'b00_01_10_11);
    chk("wrap_Z", {dCout, dZ}, 9'h100);

    // Enter and clear together: clear wins
    press(0);
    press(1);
    chk("pri_C0pre", C0, 1'b1);
    pa0 = pA;
    clrc = 0;
    ken = 1'b0;
    kclr = 1'b0;
    cyc(10);
    ken = 1'b1;
    kclr = 1'b1;
    cyc(20);
    chk("pri_clrc", clrc, 2);
    chk("pri_noA", pA, pa0);
    chk("pri_st", state, 2'd0);
    chk("pri_outs", {C0, data_out}, 9'h000);

    // Debounce: 3-cycle glitch ignored, long hold gives one event
    ken = 1'b0;
    cyc(3);
    ken = 1'b1;
    cyc(20);
    chk("glitch_noA", pA, pa0);
    sw = 8'h5A;
    ken = 1'b0;
    wait_low("deb_wait", 0, 30, n);
    chk("deb_latency", n, 8);
    cyc(40 - n);
    ken = 1'b1;
    cyc(20);
    chk("deb_onepulse", pA, pa0 + 1);
    chk("deb_A", dA, 8'h5A);

    // Op during loadB pulse is dropped
    pb0 = pB;
    sw = 8'h10;
    ken = 1'b0;
    cyc(2);
    kop = 1'b0;
    wait_low("busy_wait", 1, 30, n);
    cyc(15);
    ken = 1'b1;
    kop = 1'b1;
    cyc(20);
    wait_idle("busy_idle");
    chk("busy_C0", C0, 1'b0);
    chk("busy_st", state, 2'd3);
    chk("busy_onepulse", pB, pb0 + 1);

    // Reset in the middle of a loadA pulse
    press(0);
    press(1);
    sw = 8'hAA;
    ken = 1'b0;
    wait_low("rstp_wait", 0, 30, n);
    CLR = 1'b1;
    #1;
    chk("rstp_loadA", loadA, 1'b1);
    chk("rstp_st", state, 2'd0);
    chk("rstp_outs", {C0, busy, clr_out, data_out}, 11'h000);
    cyc(2);
    ken = 1'b1;
    cyc(1);
    CLR = 1'b0;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
